// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a 2**ADDRW byte FIFO in front of it.
// A byte offered while the FIFO is full is dropped, and the sticky overflow flag is set.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int ADDRW       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             full,
  output logic             overflow,
  output logic [ADDRW:0]   count,
  output logic             busy,
  output logic             txd
);
  localparam int DEPTH = 2 ** ADDRW;
  localparam int TW    = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0]  T_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [ADDRW:0] CNT_FULL = (ADDRW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       mem_q [DEPTH];
  logic [ADDRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDRW:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             empty, full_w, wr, pop, t_last;

  assign full_w = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign t_last = (timer_q == T_LAST);
  assign wr     = din_valid && !full_w;
  // Head byte leaves the FIFO as a new frame starts, either from IDLE or straight out of STOP.
  assign pop    = !empty && ((state_q == IDLE) || ((state_q == STOP) && t_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= din;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = START;
      START:   if (t_last) state_d = DATA;
      DATA:    if (t_last && (bit_q == 3'd7)) state_d = STOP;
      STOP:    if (t_last) state_d = empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d     = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    overflow_d = overflow_q | (din_valid & full_w);
    case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    timer_d = (state_q == IDLE || t_last) ? '0 : timer_q + TW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shreg_d = mem_q[rptr_q];
          txd_d   = 1'b0;
        end
      end
      START: if (t_last) begin
        txd_d = shreg_q[0];
        bit_d = 3'd0;
      end
      DATA: if (t_last) begin
        if (bit_q == 3'd7) begin
          txd_d = 1'b1;
        end else begin
          shreg_d = shreg_q >> 1;
          txd_d   = shreg_q[1];
          bit_d   = bit_q + 3'd1;
        end
      end
      STOP: if (t_last) begin
        if (pop) begin
          shreg_d = mem_q[rptr_q];
          txd_d   = 1'b0;
        end else begin
          txd_d = 1'b1;
        end
      end
      default: txd_d = 1'b1;
    endcase
  end

  assign full     = full_w;
  assign overflow = overflow_q;
  assign count    = count_q;
  assign busy     = (state_q != IDLE) || !empty;
  assign txd      = txd_q;
endmodule
